// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator bank.
//   OP_*      : ACOp encodings
//   acc_next  : computes {carry, result} for one op on one accumulator value.
//               Operands are carried zero-extended in MAX_W-bit containers so
//               one function serves every WIDTH (WIDTH must be < MAX_W).
package acc_pkg;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_CLR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_ADD  = 3'b111;

   localparam int MAX_W = 64;

   typedef struct packed {
      logic             carry;
      logic [MAX_W-1:0] res;
   } acc_res_t;

   function automatic acc_res_t acc_next(input logic [2:0]       op,
                                         input logic [MAX_W-1:0] acc,
                                         input logic [MAX_W-1:0] opnd,
                                         input int               width,
                                         input bit               sat);
      logic [MAX_W-1:0] ones;
      logic [MAX_W:0]   sum;
      acc_res_t         r;
      ones    = {MAX_W{1'b1}} >> (MAX_W - width);
      sum     = '0;
      r.carry = 1'b0;
      r.res   = acc;
      case (op)
         OP_LOAD: r.res = opnd & ones;
         OP_INC: begin
            sum     = {1'b0, acc} + (MAX_W+1)'(1);
            r.carry = (acc == ones);
            r.res   = (r.carry && sat) ? ones : (sum[MAX_W-1:0] & ones);
         end
         OP_DEC: begin
            sum     = {1'b0, acc} - (MAX_W+1)'(1);
            r.carry = (acc == '0);
            r.res   = (r.carry && sat) ? '0 : (sum[MAX_W-1:0] & ones);
         end
         OP_CLR: r.res = '0;
         OP_SHL: begin
            // ones ^ (ones >> 1) isolates the MSB of a WIDTH-bit value
            r.carry = |(acc & (ones ^ (ones >> 1)));
            r.res   = (acc << 1) & ones;
         end
         OP_SHR: begin
            r.carry = acc[0];
            r.res   = acc >> 1;
         end
         OP_ADD: begin
            // both operands < 2^width, so the bit above width is the carry
            sum     = {1'b0, acc} + {1'b0, opnd};
            r.carry = |(sum >> width);
            r.res   = (r.carry && sat) ? ones : (sum[MAX_W-1:0] & ones);
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/acc_channel.sv
// acc_channel: one WIDTH-bit accumulator register.
//   CLK, RST : clock, synchronous active-high reset
//   enable   : apply op at this edge
//   op       : ACOp code
//   ALUin    : operand for LOAD/ADD
//   value    : current register contents
//   carry    : carry/borrow/shift-out this op would produce (combinational)
module acc_channel
   import acc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] ALUin,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   acc_res_t r;
   logic     unused_hi;

   always_comb r = acc_next(op, MAX_W'(value), MAX_W'(ALUin), WIDTH, SATURATE);

   assign carry     = r.carry;
   assign unused_hi = ^r.res[MAX_W-1:WIDTH];

   always_ff @(posedge CLK) begin
      if (RST)
         value <= '0;
      else if (enable)
         value <= r.res[WIDTH-1:0];
   end

endmodule

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators sharing one op port.
//   CLK, RST : clock, synchronous active-high reset
//   ALUin    : operand for LOAD/ADD
//   ACOp     : operation code (acc_pkg OP_*)
//   ACSel    : target of ACOp and source of ACout
//   ACout    : selected accumulator, 0 when ACSel is out of range
//   Z, N     : zero / sign of ACout (combinational)
//   C        : registered carry flag of the last non-HOLD op
module acc_bank
   import acc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_ACC  = 4,
   parameter int SATURATE = 0,
   parameter int SEL_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] ALUin,
   input  logic [2:0]       ACOp,
   input  logic [SEL_W-1:0] ACSel,
   output logic [WIDTH-1:0] ACout,
   output logic             Z,
   output logic             N,
   output logic             C
);

   localparam logic [SEL_W:0] NUM_ACC_V = (SEL_W+1)'(NUM_ACC);

   logic [NUM_ACC-1:0][WIDTH-1:0] vals;
   logic [NUM_ACC-1:0]            cands;
   logic [NUM_ACC-1:0]            en;
   logic                          cand_sel;
   logic                          in_range;

   assign in_range = ({1'b0, ACSel} < NUM_ACC_V);

   for (genvar g = 0; g < NUM_ACC; g++) begin : g_ch
      acc_channel #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE != 0)
      ) u_ch (
         .CLK    (CLK),
         .RST    (RST),
         .enable (en[g]),
         .op     (ACOp),
         .ALUin  (ALUin),
         .value  (vals[g]),
         .carry  (cands[g])
      );
   end

   // out-of-range selects match no channel: no enable, ACout stays 0
   always_comb begin
      en       = '0;
      ACout    = '0;
      cand_sel = 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (ACSel == SEL_W'(i)) begin
            en[i]    = (ACOp != OP_HOLD);
            ACout    = vals[i];
            cand_sel = cands[i];
         end
      end
   end

   assign Z = (ACout == '0);
   assign N = ACout[WIDTH-1];

   always_ff @(posedge CLK) begin
      if (RST)
         C <= 1'b0;
      else if (in_range && (ACOp != OP_HOLD))
         C <= cand_sel;
   end

endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: scoreboard bench for acc_bank.
//   DUT 0: WIDTH=8 NUM_ACC=4 wrap mode
//   DUT 1: WIDTH=8 NUM_ACC=4 saturating
//   DUT 2: WIDTH=8 NUM_ACC=3 (out-of-range select)
module tb_acc_bank;
   import acc_pkg::*;

   typedef struct {
      int         dut;
      logic [7:0] v;
      logic       z;
      logic       n;
      logic       c;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] alu;
   logic [2:0] op   [3];
   logic [1:0] sel  [3];
   logic [7:0] acout[3];
   logic       z    [3];
   logic       n    [3];
   logic       c    [3];
   logic       obs;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   acc_bank #(.WIDTH(8), .NUM_ACC(4), .SATURATE(0)) u_wrap (
      .CLK(clk), .RST(rst), .ALUin(alu), .ACOp(op[0]), .ACSel(sel[0]),
      .ACout(acout[0]), .Z(z[0]), .N(n[0]), .C(c[0]));

   acc_bank #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1)) u_sat (
      .CLK(clk), .RST(rst), .ALUin(alu), .ACOp(op[1]), .ACSel(sel[1]),
      .ACout(acout[1]), .Z(z[1]), .N(n[1]), .C(c[1]));

   acc_bank #(.WIDTH(8), .NUM_ACC(3), .SATURATE(0)) u_oor (
      .CLK(clk), .RST(rst), .ALUin(alu), .ACOp(op[2]), .ACSel(sel[2]),
      .ACout(acout[2]), .Z(z[2]), .N(n[2]), .C(c[2]));

   // one op cycle on DUT d; every other DUT holds
   task automatic cyc(input int d, input logic [2:0] o, input logic [1:0] s,
                      input logic [7:0] a, input logic r);
      for (int i = 0; i < 3; i++) op[i] = OP_HOLD;
      op[d]  = o;
      sel[d] = s;
      alu    = a;
      rst    = r;
      obs    = 1'b0;
      @(posedge clk);
      #2;
   endtask

   // HOLD cycle reading channel s of DUT d; expectation goes to the scoreboard
   task automatic chk(input int d, input logic [1:0] s, input logic [7:0] v,
                      input logic ez, input logic en, input logic ec, input string nm);
      exp_t e;
      for (int i = 0; i < 3; i++) op[i] = OP_HOLD;
      sel[d] = s;
      rst    = 1'b0;
      e.dut = d; e.v = v; e.z = ez; e.n = en; e.c = ec; e.name = nm;
      sb.push_back(e);
      obs = 1'b1;
      @(posedge clk);
      #2;
      obs = 1'b0;
   endtask

   // monitor: samples mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (obs) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: observation with empty scoreboard", "monitor");
         end else begin
            e = sb.pop_front();
            if (acout[e.dut] !== e.v || z[e.dut] !== e.z ||
                n[e.dut] !== e.n || c[e.dut] !== e.c) begin
               failures++;
               $display("FAIL %s: got ACout=%h Z=%b N=%b C=%b, want ACout=%h Z=%b N=%b C=%b",
                        e.name, acout[e.dut], z[e.dut], n[e.dut], c[e.dut],
                        e.v, e.z, e.n, e.c);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; alu = '0; obs = 1'b0;
      for (int i = 0; i < 3; i++) begin op[i] = OP_HOLD; sel[i] = '0; end
      @(posedge clk); #2;

      // reset state, every channel of every build
      cyc(0, OP_HOLD, 2'd0, 8'h00, 1'b1);
      chk(0, 2'd0, 8'h00, 1, 0, 0, "rst_ch0");
      chk(0, 2'd1, 8'h00, 1, 0, 0, "rst_ch1");
      chk(0, 2'd2, 8'h00, 1, 0, 0, "rst_ch2");
      chk(0, 2'd3, 8'h00, 1, 0, 0, "rst_ch3");
      chk(1, 2'd0, 8'h00, 1, 0, 0, "rst_sat");
      chk(2, 2'd2, 8'h00, 1, 0, 0, "rst_oor");

      // reset wins over a simultaneous LOAD
      cyc(0, OP_LOAD, 2'd2, 8'hA5, 1'b1);
      chk(0, 2'd2, 8'h00, 1, 0, 0, "rst_over_load");

      // wrap mode on ch1
      cyc(0, OP_LOAD, 2'd1, 8'hFF, 1'b0);
      cyc(0, OP_INC,  2'd1, 8'h00, 1'b0);
      chk(0, 2'd1, 8'h00, 1, 0, 1, "inc_wrap");
      cyc(0, OP_DEC,  2'd1, 8'h00, 1'b0);
      chk(0, 2'd1, 8'hFF, 0, 1, 1, "dec_wrap");
      cyc(0, OP_LOAD, 2'd1, 8'h10, 1'b0);
      chk(0, 2'd1, 8'h10, 0, 0, 0, "load_clears_c");

      // shifts on ch3
      cyc(0, OP_LOAD, 2'd3, 8'h81, 1'b0);
      cyc(0, OP_SHL,  2'd3, 8'h00, 1'b0);
      chk(0, 2'd3, 8'h02, 0, 0, 1, "shl_msb_out");
      cyc(0, OP_SHR,  2'd3, 8'h00, 1'b0);
      chk(0, 2'd3, 8'h01, 0, 0, 0, "shr_lsb0");
      cyc(0, OP_SHR,  2'd3, 8'h00, 1'b0);
      chk(0, 2'd3, 8'h00, 1, 0, 1, "shr_lsb1");

      // channel isolation
      cyc(0, OP_LOAD, 2'd0, 8'h11, 1'b0);
      cyc(0, OP_LOAD, 2'd1, 8'h22, 1'b0);
      cyc(0, OP_LOAD, 2'd2, 8'h33, 1'b0);
      cyc(0, OP_INC,  2'd1, 8'h00, 1'b0);
      chk(0, 2'd0, 8'h11, 0, 0, 0, "iso_ch0");
      chk(0, 2'd1, 8'h23, 0, 0, 0, "iso_ch1");
      chk(0, 2'd2, 8'h33, 0, 0, 0, "iso_ch2");
      chk(0, 2'd3, 8'h00, 1, 0, 0, "iso_ch3");

      // wrapping ADD with carry out
      cyc(0, OP_LOAD, 2'd0, 8'hF0, 1'b0);
      cyc(0, OP_ADD,  2'd0, 8'h20, 1'b0);
      chk(0, 2'd0, 8'h10, 0, 0, 1, "add_wrap");
      cyc(0, OP_CLR,  2'd0, 8'h00, 1'b0);
      chk(0, 2'd0, 8'h00, 1, 0, 0, "clr");

      // saturating build
      cyc(1, OP_LOAD, 2'd0, 8'hF0, 1'b0);
      cyc(1, OP_ADD,  2'd0, 8'h20, 1'b0);
      chk(1, 2'd0, 8'hFF, 0, 1, 1, "sat_add");
      cyc(1, OP_CLR,  2'd0, 8'h00, 1'b0);
      cyc(1, OP_DEC,  2'd0, 8'h00, 1'b0);
      chk(1, 2'd0, 8'h00, 1, 0, 1, "sat_dec");
      cyc(1, OP_LOAD, 2'd1, 8'hFF, 1'b0);
      cyc(1, OP_INC,  2'd1, 8'h00, 1'b0);
      chk(1, 2'd1, 8'hFF, 0, 1, 1, "sat_inc");
      cyc(1, OP_LOAD, 2'd2, 8'h10, 1'b0);
      cyc(1, OP_ADD,  2'd2, 8'h20, 1'b0);
      chk(1, 2'd2, 8'h30, 0, 0, 0, "sat_add_noovf");

      // out-of-range select on NUM_ACC=3
      cyc(2, OP_LOAD, 2'd2, 8'h77, 1'b0);
      cyc(2, OP_LOAD, 2'd0, 8'hFF, 1'b0);
      cyc(2, OP_INC,  2'd0, 8'h00, 1'b0);
      cyc(2, OP_LOAD, 2'd3, 8'h55, 1'b0);
      chk(2, 2'd3, 8'h00, 1, 0, 1, "oor_read");
      chk(2, 2'd0, 8'h00, 1, 0, 1, "oor_ch0");
      chk(2, 2'd1, 8'h00, 1, 0, 1, "oor_ch1");
      chk(2, 2'd2, 8'h77, 0, 0, 1, "oor_ch2");

      @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
